// File: rtl/i2s_tdm_tx.sv
// i2s_tdm_tx: slave-mode I2S/TDM serial audio transmitter.
//
// Accepts one frame of CHANNELS samples per AXI-stream beat and shifts each
// sample out MSB-first on sd, one bit per falling edge of the externally
// supplied sck. A falling edge on ws (sampled on rising sck) marks the frame
// start. The MSB of slot 0 follows one sck later (I2S one-bit delay). Each
// slot is SLOT_WIDTH bits long; bits beyond WIDTH are driven as zero. One
// frame of data can be buffered in a shadow register while the current frame
// is being shifted out.
//
// Ports:
//   clk, rst_n       system clock (>= 8x sck), asynchronous active-low reset
//   input_tdata      packed frame, channel 0 in bits [WIDTH-1:0]
//   input_tvalid     frame valid
//   input_tready     high while the shadow buffer is empty
//   sck, ws          bit clock and word select, asynchronous to clk
//   sd               serial data out, updated one clk after each sck fall
//   underrun         one-clk pulse: frame started with nothing buffered
//   underrun_count   saturating underrun counter (only with the macro below)
//   frame_err        one-clk pulse: frame start arrived before the frame was sent
//
// Optional feature: define I2S_TDM_TX_UNDERRUN_CNT_EN to add underrun_count.

`timescale 1ns/1ps

module i2s_tdm_tx #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SLOT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] input_tdata,
    input  logic                      input_tvalid,
    output logic                      input_tready,
    input  logic                      sck,
    input  logic                      ws,
    output logic                      sd,
    output logic                      underrun,
`ifdef I2S_TDM_TX_UNDERRUN_CNT_EN
    output logic [15:0]               underrun_count,
`endif
    output logic                      frame_err
);

    localparam int unsigned FrameW   = CHANNELS * WIDTH;
    localparam int unsigned BitCntW  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int unsigned SlotCntW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BitCntW-1:0]  BitLast  = BitCntW'(SLOT_WIDTH - 1);
    localparam logic [SlotCntW-1:0] SlotLast = SlotCntW'(CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StActive, StPad} state_e;

    state_e              state_q;
    logic [2:0]          sck_sync_q;   // [1:0] synchroniser, [2] edge-detect history
    logic [1:0]          ws_sync_q;
    logic                ws_prev_q;    // ws as seen on the previous sck rise
    logic [BitCntW-1:0]  bit_cnt_q;
    logic [SlotCntW-1:0] slot_cnt_q;
    logic [WIDTH-1:0]    cur_q;        // current slot, shifted left with zero fill
    logic [FrameW-1:0]   rest_q;       // slots not yet started, next one in the low bits
    logic [FrameW-1:0]   shadow_q;
    logic                shadow_valid_q;
    logic                tready_q;
    logic                sd_q;
    logic                underrun_q;
    logic                frame_err_q;

    logic                sck_rise;
    logic                sck_fall;
    logic                frame_start;
    logic                accept;
    logic                shadow_valid_d;
    logic [FrameW-1:0]   load_frame;

    always_comb begin
        sck_rise       = sck_sync_q[1] & ~sck_sync_q[2];
        sck_fall       = ~sck_sync_q[1] & sck_sync_q[2];
        frame_start    = sck_rise & ~ws_sync_q[1] & ws_prev_q;
        accept         = input_tvalid & tready_q;
        // Accept is impossible while the shadow is full, so it never races the clear.
        shadow_valid_d = accept | (shadow_valid_q & ~frame_start);
        load_frame     = shadow_valid_q ? shadow_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q     <= '0;
            ws_sync_q      <= '0;
            ws_prev_q      <= 1'b0;
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            slot_cnt_q     <= '0;
            cur_q          <= '0;
            rest_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            tready_q       <= 1'b0;
            sd_q           <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck};
            ws_sync_q  <= {ws_sync_q[0], ws};
            if (sck_rise) begin
                ws_prev_q <= ws_sync_q[1];
            end

            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            shadow_valid_q <= shadow_valid_d;
            tready_q       <= ~shadow_valid_d;
            if (accept) begin
                shadow_q <= input_tdata;
            end

            if (frame_start) begin
                // Reload from the shadow (or zeros) regardless of where we were.
                cur_q       <= load_frame[WIDTH-1:0];
                rest_q      <= load_frame >> WIDTH;
                bit_cnt_q   <= '0;
                slot_cnt_q  <= '0;
                state_q     <= StActive;
                underrun_q  <= ~shadow_valid_q;
                frame_err_q <= (state_q == StActive);
            end else if (sck_fall) begin
                case (state_q)
                    StActive: begin
                        sd_q <= cur_q[WIDTH-1];
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_q <= '0;
                            cur_q     <= rest_q[WIDTH-1:0];
                            rest_q    <= rest_q >> WIDTH;
                            if (slot_cnt_q == SlotLast) begin
                                slot_cnt_q <= '0;
                                state_q    <= StPad;
                            end else begin
                                slot_cnt_q <= slot_cnt_q + SlotCntW'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                            cur_q     <= cur_q << 1;
                        end
                    end
                    StPad:   sd_q <= 1'b0;
                    default: sd_q <= 1'b0;
                endcase
            end
        end
    end

`ifdef I2S_TDM_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count_q <= '0;
        end else if (underrun_q && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

    assign input_tready = tready_q;
    assign sd           = sd_q;
    assign underrun     = underrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: doc/i2s_tdm_tx.md
Name: i2s_tdm_tx

Overview:
Parametrised slave-mode I2S/TDM serial audio transmitter. It accepts one frame of CHANNELS samples per AXI-stream beat and serialises them MSB-first onto sd, using externally supplied sck and ws. It generalises the two-channel I2S transmitter to N-slot TDM with a configurable slot width, a one-frame double buffer, frame-length checking and underrun signalling. It sits between the DSP sample pipeline and the codec/DAC pins.

Parameters:
WIDTH, 16, sample bits per channel
CHANNELS, 2, slots per frame (2 = standard I2S; >2 = TDM)
SLOT_WIDTH, 32, sck cycles per slot; must be >= WIDTH, and the excess LSBs are zero-padded

Ports:
clk  input  1  system clock; must be >= 8x sck frequency
rst_n  input  1  asynchronous active-low reset
input_tdata  input  CHANNELS*WIDTH  packed frame; channel 0 in bits [WIDTH-1:0]
input_tvalid  input  1  frame valid
input_tready  output  1  frame accepted when tvalid and tready
sck  input  1  serial bit clock, asynchronous to clk
ws  input  1  word select / frame sync, asynchronous to clk
sd  output  1  serial data
underrun  output  1  one-clk pulse: frame started with no buffered data
frame_err  output  1  one-clk pulse: frame start arrived before all CHANNELS*SLOT_WIDTH bits were sent

Behaviour:
- Reset (rst_n low, async): sd=0, input_tready=0, underrun=0, frame_err=0, shadow empty, state IDLE, all counters 0. input_tready goes to 1 on the first clk edge after reset release.
- sck and ws each pass through a 2-flop synchroniser. Edge detection on the synchronised sck gives sck_rise and sck_fall strobes, each one clk wide.
- Frame start: on sck_rise, ws sampled 0 where the previous sck_rise sample was 1 (ws falling edge).
- Shadow buffer, one frame: input_tready = !shadow_valid, registered. An accept loads the shadow and sets shadow_valid.
- At frame start:
  - If shadow_valid: copy the shadow into the shift register, clear shadow_valid; input_tready returns to 1 on the next clk.
  - Otherwise: load all zeros and pulse underrun.
  - An accept in the same clk as frame start goes to the shadow and serves the next frame; that frame still counts as an underrun.
- States:
  - IDLE: sd=0. Go to ACTIVE at the first frame start.
  - ACTIVE: on each sck_fall, drive the next bit. The MSB of slot 0 is driven on the first sck_fall after the frame-start sck_rise (I2S one-bit delay).
  - Bit counter runs 0..SLOT_WIDTH-1. Bits 0..WIDTH-1 are sample MSB..LSB; bits WIDTH..SLOT_WIDTH-1 drive 0. Slot counter runs 0..CHANNELS-1.
  - After bit SLOT_WIDTH-1 of slot CHANNELS-1: go to PAD.
  - PAD: sd=0 on every sck_fall until the next frame start, then reload and return to ACTIVE.
- Early frame start while in ACTIVE: pulse frame_err, abandon the remaining bits, and reload per the frame-start rule in the same clk.
- sd timing: sd changes 1 clk after the sck_fall strobe and is held otherwise.
- sck stopped: state and outputs hold indefinitely.
- A reset mid-frame returns to IDLE; a buffered frame is discarded.

Optional Feature:
- Macro I2S_TDM_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_count [15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and resets to 0 only via rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- CHANNELS=2, WIDTH=16, SLOT_WIDTH=16. Send frame L=16'hA5C3, R=16'h0F01 before the first ws fall -> sd carries bits 1010010111000011 then 0000111100000001 on successive sck_fall, starting one sck after the ws fall; underrun never pulses.
- CHANNELS=4, WIDTH=16, SLOT_WIDTH=32, ws pulse every 128 sck. Channels 0..3 = 16'h8001, 16'h4002, 16'h2004, 16'h1008 -> each slot shows the 16 data bits followed by 16 zeros, in channel order.
- No tvalid across two frame starts -> sd all zeros and exactly two underrun pulses; with the macro defined, underrun_count=2.
- Frame of 100 sck with CHANNELS=4, SLOT_WIDTH=32 (needs 128 bits) -> frame_err pulses once at the early start, and the next frame starts cleanly with the MSB of slot 0.
- Hold tvalid with data continuously -> input_tready drops after the accept and rises 1 clk after each frame start; exactly one beat is accepted per frame.
- Assert rst_n low mid-slot -> sd=0 and input_tready=0 immediately; after release, sd stays 0 until the next ws fall.
